// File: rtl/siso_frame_ctrl_if.sv
// Word-side handshake bundle for siso_frame_ctrl.
// Input stream (in_*) and returned-word stream (out_*, mismatch).
interface siso_frame_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             mismatch;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  mismatch
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output mismatch
  );
endinterface

// File: rtl/siso_frame_ctrl.sv
// Loopback sequencer for a free-running SISO chain: serialises a word
// MSB-first, flushes with zeros, captures the echo and compares it.
module siso_frame_ctrl #(
  parameter int WIDTH     = 8,
  parameter int CHAIN_LAT = 8,
  parameter int ERRW      = 8
) (
  input  logic            clk,
  input  logic            rst,
  siso_frame_ctrl_if.slave sif,
  output logic            ser_sin,
  input  logic            ser_sout,
  output logic            busy,
  output logic [ERRW-1:0] err_cnt
);

  localparam int TOT = WIDTH + CHAIN_LAT;
  localparam int CW  = $clog2(TOT);

  localparam logic [CW-1:0] TX_END  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CAP_BEG = CW'(CHAIN_LAT);
  localparam logic [CW-1:0] LAST    = CW'(TOT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FLUSH,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic [WIDTH-1:0] sent;
  logic [WIDTH-1:0] out_data_q;
  logic [CW-1:0]    cnt;
  logic             out_valid_q;
  logic             mismatch_q;

  logic             accept;
  logic             in_flight;
  logic             cap;
  logic             cap_end;
  logic             out_hs;
  logic             rx_bad;
  logic [WIDTH-1:0] rx_nx;

  assign in_flight = (state == SHIFT) || (state == FLUSH);
  assign accept    = (state == IDLE) && sif.in_valid;
  assign cap       = in_flight && (cnt >= CAP_BEG);
  assign cap_end   = in_flight && (cnt == LAST);
  assign out_hs    = (state == DONE) && sif.out_ready;
  assign rx_nx     = {rx_sr[WIDTH-2:0], ser_sout};
  assign rx_bad    = (rx_nx != sent);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (sif.in_valid) state_nx = SHIFT;
      SHIFT: if (cnt == TX_END) state_nx = FLUSH;
      FLUSH: if (cnt == LAST) state_nx = DONE;
      DONE:  if (sif.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // tx_sr drains to zero by the end of every frame, so ser_sin idles low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sr <= '0;
      sent  <= '0;
      cnt   <= '0;
    end else if (accept) begin
      tx_sr <= sif.in_data;
      sent  <= sif.in_data;
      cnt   <= '0;
    end else if (in_flight) begin
      tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
      cnt   <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sr <= '0;
    end else if (cap) begin
      rx_sr <= rx_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
    end else if (cap_end) begin
      out_data_q  <= rx_nx;
      out_valid_q <= 1'b1;
      mismatch_q  <= rx_bad;
    end else if (out_hs) begin
      out_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (cap_end && rx_bad && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERRW'(1);
    end
  end

  assign ser_sin       = tx_sr[WIDTH-1];
  assign busy          = (state != IDLE);
  assign sif.in_ready  = (state == IDLE);
  assign sif.out_valid = out_valid_q;
  assign sif.out_data  = out_data_q;
  assign sif.mismatch  = mismatch_q;

endmodule

// File: tb/tb_siso_frame_ctrl.sv
// Directed bench: siso_frame_ctrl with an 8-deep SISO chain model.
// Optional one-cycle inversion on the chain output forces errors.
module tb_siso_frame_ctrl;

  logic       clk;
  logic       rst;
  logic       ser_sin;
  logic       ser_sout;
  logic       busy;
  logic [7:0] err_cnt;
  logic [7:0] chain;
  int         cyc;
  int         flip_cyc;
  int         n_cmp;
  int         n_bad;

  siso_frame_ctrl_if #(.WIDTH(8)) sif ();

  siso_frame_ctrl #(
    .WIDTH(8),
    .CHAIN_LAT(8),
    .ERRW(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sif(sif),
    .ser_sin(ser_sin),
    .ser_sout(ser_sout),
    .busy(busy),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[6:0], ser_sin};
  end

  always @(posedge clk) cyc <= cyc + 1;

  assign ser_sout = chain[7] ^ (cyc == flip_cyc);

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_out(input string tag, input logic [7:0] exp_d,
                          input logic exp_mm);
    int n;
    n = 0;
    while (!sif.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, 16);
    chk({tag, "_data"}, sif.out_data, exp_d);
    chk({tag, "_mm"}, sif.mismatch, exp_mm);
  endtask

  task automatic frame(input logic [7:0] d, input logic [7:0] exp_d,
                       input logic exp_mm, input int flip_off,
                       input string tag);
    chk({tag, "_rdy"}, sif.in_ready, 1);
    sif.in_valid = 1'b1;
    sif.in_data  = d;
    flip_cyc = (flip_off >= 0) ? cyc + 1 + flip_off : -1;
    @(negedge clk);
    sif.in_valid = 1'b0;
    wait_out(tag, exp_d, exp_mm);
  endtask

  initial begin
    logic [15:0] pat;
    int c1;
    int c2;
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    flip_cyc = -1;
    rst = 1'b1;
    sif.in_valid  = 1'b0;
    sif.in_data   = '0;
    sif.out_ready = 1'b1;

    // T1 reset
    repeat (2) @(negedge clk);
    chk("t1_rdy", sif.in_ready, 1);
    chk("t1_busy", busy, 0);
    chk("t1_sin", ser_sin, 0);
    chk("t1_ov", sif.out_valid, 0);
    chk("t1_mm", sif.mismatch, 0);
    chk("t1_err", err_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_rdy2", sif.in_ready, 1);

    // T2 single frame, serial pattern and latency
    pat = {8'hB3, 8'h00};
    sif.in_valid = 1'b1;
    sif.in_data  = 8'hB3;
    @(negedge clk);
    sif.in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t2_sin%0d", k), ser_sin, pat[15-k]);
      chk($sformatf("t2_ov%0d", k), sif.out_valid, 0);
      @(negedge clk);
    end
    chk("t2_ov", sif.out_valid, 1);
    chk("t2_data", sif.out_data, 8'hB3);
    chk("t2_mm", sif.mismatch, 0);
    chk("t2_busy", busy, 1);
    chk("t2_rdy", sif.in_ready, 0);
    @(negedge clk);
    chk("t2_ov_clr", sif.out_valid, 0);
    chk("t2_rdy2", sif.in_ready, 1);

    // T3 backpressure with a pending word
    sif.out_ready = 1'b0;
    frame(8'h96, 8'h96, 1'b0, -1, "t3a");
    sif.in_valid = 1'b1;
    sif.in_data  = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t3_ov%0d", i), sif.out_valid, 1);
      chk($sformatf("t3_d%0d", i), sif.out_data, 8'h96);
      chk($sformatf("t3_rdy%0d", i), sif.in_ready, 0);
    end
    sif.out_ready = 1'b1;
    @(negedge clk);
    chk("t3_ov_clr", sif.out_valid, 0);
    chk("t3_rdy", sif.in_ready, 1);
    chk("t3_busy", busy, 0);
    @(negedge clk);
    chk("t3_acc", busy, 1);
    sif.in_valid = 1'b0;
    wait_out("t3b", 8'h5A, 1'b0);
    @(negedge clk);

    // T4 back-to-back with in_valid held high
    sif.in_valid = 1'b1;
    sif.in_data  = 8'h01;
    @(negedge clk);
    sif.in_data = 8'h80;
    wait_out("t4a", 8'h01, 1'b0);
    c1 = cyc;
    @(negedge clk);
    @(negedge clk);
    sif.in_valid = 1'b0;
    wait_out("t4b", 8'h80, 1'b0);
    c2 = cyc;
    chk("t4_gap", c2 - c1, 18);
    @(negedge clk);

    // T5 forced errors and counter saturation
    frame(8'hFF, 8'hDF, 1'b1, 10, "t5a");
    chk("t5_err1", err_cnt, 8'h01);
    @(negedge clk);
    chk("t5_mm_clr", sif.mismatch, 0);
    for (int i = 0; i < 253; i++) begin
      frame(8'hFF, 8'hDF, 1'b1, 10, "t5l");
      @(negedge clk);
    end
    chk("t5_errFE", err_cnt, 8'hFE);
    frame(8'hFF, 8'hDF, 1'b1, 10, "t5b");
    chk("t5_errFF", err_cnt, 8'hFF);
    @(negedge clk);
    frame(8'hFF, 8'hDF, 1'b1, 10, "t5c");
    chk("t5_sat", err_cnt, 8'hFF);
    @(negedge clk);
    frame(8'h42, 8'h42, 1'b0, -1, "t5d");
    chk("t5_hold", err_cnt, 8'hFF);
    @(negedge clk);

    // T6 reset in the middle of a frame
    sif.in_valid = 1'b1;
    sif.in_data  = 8'hC3;
    @(negedge clk);
    sif.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("t6_rdy", sif.in_ready, 1);
    chk("t6_busy", busy, 0);
    chk("t6_sin", ser_sin, 0);
    chk("t6_ov", sif.out_valid, 0);
    chk("t6_mm", sif.mismatch, 0);
    chk("t6_err", err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    frame(8'h3C, 8'h3C, 1'b0, -1, "t6b");
    chk("t6_err2", err_cnt, 0);
    @(negedge clk);
    chk("t6_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
